// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder definitions: opcodes, field-bundle kind codes, loader FSM states.
// The opcode values are the same ones the core's control decoder matches against.
package rv_enc_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // Codes 6 and 7 are deliberately left out; they are rejected as illegal kinds.
    typedef enum logic [2:0] {
        KIND_R   = 3'd0,
        KIND_I   = 3'd1,
        KIND_LW  = 3'd2,
        KIND_SW  = 3'd3,
        KIND_BEQ = 3'd4,
        KIND_JAL = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } state_e;

    function automatic logic imm_fits(input logic [31:0] imm,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational immediate scatter: places in_imm bits where each format expects them
// and flags whether the immediate is representable (range and alignment).
module imm_packer
    import rv_enc_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [31:0] imm,
    output logic [31:0] placed,
    output logic        in_range
);

    // Non-immediate bit positions stay zero so the top can OR in its fixed fields.
    always_comb begin
        placed   = '0;
        in_range = 1'b0;
        case (kind)
            KIND_R: begin
                in_range = 1'b1;
            end
            KIND_I, KIND_LW: begin
                placed   = {imm[11:0], 20'b0};
                in_range = imm_fits(imm, -32'sd2048, 32'sd2047);
            end
            KIND_SW: begin
                placed   = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                in_range = imm_fits(imm, -32'sd2048, 32'sd2047);
            end
            KIND_BEQ: begin
                placed   = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                in_range = imm_fits(imm, -32'sd4096, 32'sd4094) && !imm[0];
            end
            KIND_JAL: begin
                placed   = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                in_range = imm_fits(imm, -32'sd1048576, 32'sd1048574) && !imm[0];
            end
            default: begin
                in_range = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder and instruction-memory loader.
// Accepts field bundles, packs machine words and writes them to consecutive word addresses.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int               ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       placed;
    logic              in_range;
    logic [31:0]       word;
    logic              transfer;
    logic              accept;
    logic              reject;
    logic              hit_last;

    imm_packer u_imm_packer (
        .kind     (in_kind),
        .imm      (in_imm),
        .placed   (placed),
        .in_range (in_range)
    );

    assign in_ready = (state == ST_RUN) && !start;
    assign transfer = in_valid && in_ready;
    assign accept   = transfer && in_range;
    assign reject   = transfer && !in_range;
    assign hit_last = accept && (next_addr == LAST_ADDR);

    // Fixed fields per format; immediate bits arrive pre-placed from imm_packer.
    always_comb begin
        word = placed;
        case (in_kind)
            KIND_R:   word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            KIND_I:   word = placed | {12'b0, in_rs1, in_funct3, in_rd, OP_I};
            KIND_LW:  word = placed | {12'b0, in_rs1, F3_WORD, in_rd, OP_LW};
            KIND_SW:  word = placed | {7'b0, in_rs2, in_rs1, F3_WORD, 5'b0, OP_SW};
            KIND_BEQ: word = placed | {7'b0, in_rs2, in_rs1, F3_BEQ, 5'b0, OP_BEQ};
            KIND_JAL: word = placed | {20'b0, in_rd, OP_JAL};
            default:  word = placed;
        endcase
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_RUN;
        end else if ((state == ST_RUN) && hit_last) begin
            state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The address never wraps: after the last word it parks and FULL blocks input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wd    <= '0;
            next_addr  <= BASE_ADDR;
            full       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= accept;
            if (start) begin
                imem_addr  <= BASE_ADDR;
                next_addr  <= BASE_ADDR;
                full       <= 1'b0;
                err        <= 1'b0;
                word_count <= '0;
            end else begin
                if (accept) begin
                    imem_addr  <= next_addr;
                    imem_wd    <= word;
                    word_count <= word_count + (ADDR_W+1)'(1);
                    if (hit_last) begin
                        full <= 1'b1;
                    end else begin
                        next_addr <= next_addr + ADDR_W'(1);
                    end
                end
                if (reject) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
